// File: rtl/between_to_fifo_crc.sv
// Between-stage to TX FIFO bridge: four-phase word intake, serial CRC (BPC bits/cycle),
// FIFO write per word and an appended CRC word at end of packet.
module between_to_fifo_crc #(
    parameter int              DATA_W   = 8,
    parameter int              BPC      = 1,
    parameter int              CRC_W    = 8,
    parameter logic [CRC_W-1:0] POLY     = 8'h07,
    parameter logic [CRC_W-1:0] CRC_INIT = 8'h00,
    parameter int              MAX_LEN  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] t_data,
    input  logic              t_last,
    input  logic              tsent,
    output logic              trecieve,
    input  logic              fifo_busy,
    output logic              fifo_we,
    output logic [DATA_W-1:0] fifo_data,
    output logic [CRC_W-1:0]  CRC,
    output logic              isFinish,
    output logic [3:0]        error
);
    localparam int STEPS = DATA_W / BPC;
    localparam int SC_W  = $clog2(STEPS + 1);
    localparam int CNT_W = $clog2(MAX_LEN + 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_CRC, S_WR, S_ACK, S_CRCW} state_t;

    state_t             state_reg, state_next;
    logic [CRC_W-1:0]   crc_reg;
    logic [DATA_W-1:0]  shift_reg;
    logic [DATA_W-1:0]  fifo_data_reg;
    logic [SC_W-1:0]    step_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [7:0]         wait_reg;
    logic [3:0]         error_reg;
    logic               last_reg;
    logic               ack_first_reg;
    logic               pkt_end;
    logic               busy_wait;

    // BPC single-bit CRC steps chained, consuming the shift register MSB first
    logic [CRC_W-1:0] crc_chain [0:BPC];
    assign crc_chain[0] = crc_reg;

    genvar gi;
    for (gi = 0; gi < BPC; gi++) begin : g_crc_step
        logic fb;
        assign fb = crc_chain[gi][CRC_W-1] ^ shift_reg[DATA_W-1-gi];
        assign crc_chain[gi+1] = {crc_chain[gi][CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end

    assign pkt_end   = last_reg || (count_reg == CNT_W'(MAX_LEN));
    assign busy_wait = ((state_reg == S_WR) || (state_reg == S_CRCW)) && fifo_busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (enable) begin
            case (state_reg)
                S_IDLE:  state_next = S_WAIT;
                S_WAIT:  if (tsent) state_next = S_CRC;
                S_CRC:   if (step_reg == '0) state_next = S_WR;
                S_WR:    if (!fifo_busy) state_next = S_ACK;
                S_ACK:   if (!tsent) state_next = pkt_end ? S_CRCW : S_WAIT;
                S_CRCW:  if (!fifo_busy) state_next = S_WAIT;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // The ack is forced high on the first S_ACK cycle so an early-dropped request still sees a pulse
    always_comb begin
        isFinish = (state_reg == S_WAIT);
        trecieve = (state_reg == S_ACK) && (tsent || ack_first_reg);
        fifo_we  = enable && !fifo_busy && ((state_reg == S_WR) || (state_reg == S_CRCW));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            crc_reg       <= CRC_INIT;
            shift_reg     <= '0;
            fifo_data_reg <= '0;
            step_reg      <= '0;
            count_reg     <= '0;
            wait_reg      <= '0;
            error_reg     <= '0;
            last_reg      <= 1'b0;
            ack_first_reg <= 1'b0;
        end else if (enable) begin
            ack_first_reg <= 1'b0;
            if (busy_wait) begin
                if (wait_reg == 8'hFF) error_reg[2] <= 1'b1;
                else                   wait_reg <= wait_reg + 8'd1;
            end else begin
                wait_reg <= '0;
            end
            case (state_reg)
                S_IDLE: begin
                    if (tsent) error_reg[3] <= 1'b1;
                end
                S_WAIT: begin
                    if (tsent) begin
                        fifo_data_reg <= t_data;
                        shift_reg     <= t_data;
                        last_reg      <= t_last;
                        step_reg      <= SC_W'(STEPS - 1);
                    end
                end
                S_CRC: begin
                    crc_reg   <= crc_chain[BPC];
                    shift_reg <= shift_reg << BPC;
                    step_reg  <= step_reg - 1'b1;
                    if (!tsent) error_reg[1] <= 1'b1;
                end
                S_WR: begin
                    if (!tsent) error_reg[1] <= 1'b1;
                    if (!fifo_busy) begin
                        count_reg     <= count_reg + 1'b1;
                        ack_first_reg <= 1'b1;
                    end
                end
                S_ACK: begin
                    if (!tsent && pkt_end) begin
                        fifo_data_reg <= DATA_W'(crc_reg);
                        if (!last_reg) error_reg[0] <= 1'b1;
                    end
                end
                S_CRCW: begin
                    if (!fifo_busy) begin
                        crc_reg   <= CRC_INIT;
                        count_reg <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign fifo_data = fifo_data_reg;
    assign CRC       = crc_reg;
    assign error     = error_reg;

endmodule

// File: tb/tb_between_to_fifo_crc.sv
// Directed bench for between_to_fifo_crc: three instances (default, BPC=4, MAX_LEN=4)
// share one stimulus stream; FIFO writes are collected per instance and compared.
module tb_between_to_fifo_crc;
    localparam int BIG = 1 << 20;

    logic       clk, reset, enable, t_last, tsent, fifo_busy;
    logic [7:0] t_data;
    logic       trecieve0, trecieve1, trecieve2;
    logic       fifo_we0, fifo_we1, fifo_we2;
    logic [7:0] fifo_data0, fifo_data1, fifo_data2;
    logic [7:0] crc0, crc1, crc2;
    logic       fin0, fin1, fin2;
    logic [3:0] error0, error1, error2;

    between_to_fifo_crc u_dut0 (
        .clk(clk), .reset(reset), .enable(enable), .t_data(t_data), .t_last(t_last),
        .tsent(tsent), .trecieve(trecieve0), .fifo_busy(fifo_busy), .fifo_we(fifo_we0),
        .fifo_data(fifo_data0), .CRC(crc0), .isFinish(fin0), .error(error0));
    between_to_fifo_crc #(.BPC(4)) u_dut1 (
        .clk(clk), .reset(reset), .enable(enable), .t_data(t_data), .t_last(t_last),
        .tsent(tsent), .trecieve(trecieve1), .fifo_busy(fifo_busy), .fifo_we(fifo_we1),
        .fifo_data(fifo_data1), .CRC(crc1), .isFinish(fin1), .error(error1));
    between_to_fifo_crc #(.MAX_LEN(4)) u_dut2 (
        .clk(clk), .reset(reset), .enable(enable), .t_data(t_data), .t_last(t_last),
        .tsent(tsent), .trecieve(trecieve2), .fifo_busy(fifo_busy), .fifo_we(fifo_we2),
        .fifo_data(fifo_data2), .CRC(crc2), .isFinish(fin2), .error(error2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] q0[$], q1[$], q2[$], exp_q[$];
    int         viol = 0;
    int         b[3];
    int         lat_we[3];
    int         lat_ack0;
    int         checks = 0;
    int         errors = 0;

    always @(negedge clk) begin
        if (fifo_we0) q0.push_back(fifo_data0);
        if (fifo_we1) q1.push_back(fifo_data1);
        if (fifo_we2) q2.push_back(fifo_data2);
        if ((fifo_we0 || fifo_we1 || fifo_we2) && fifo_busy) viol++;
    end

    typedef struct {
        logic [7:0] d;
        logic       l;
        int         hold;
        int         drop_at;
        int         es;
        int         el;
        int         lat0;
        int         ack0;
        int         lat1;
        logic [7:0] crcw;
        logic [3:0] err0;
    } vec_t;
    vec_t vec [8];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic chk_stream(input string nm, input int which);
        string gs, es;
        bit    ok;
        int    n;
        logic [7:0] v;
        gs = ""; es = "";
        n  = (which == 0) ? q0.size() : (which == 1) ? q1.size() : q2.size();
        ok = ((n - b[which]) == exp_q.size());
        for (int i = b[which]; i < n; i++) begin
            v  = (which == 0) ? q0[i] : (which == 1) ? q1[i] : q2[i];
            gs = {gs, $sformatf(" %02h", v)};
            if ((i - b[which]) < exp_q.size() && v !== exp_q[i - b[which]]) ok = 0;
        end
        foreach (exp_q[i]) es = {es, $sformatf(" %02h", exp_q[i])};
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s got{%s} exp{%s}", nm, gs, es);
        end
    endtask

    task automatic mark();
        b[0] = q0.size(); b[1] = q1.size(); b[2] = q2.size();
    endtask

    // Leaves all instances in S_WAIT at posedge+1
    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0; tsent = 1'b0; fifo_busy = 1'b0; enable = 1'b1; t_last = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        mark();
    endtask

    // Cycle n=0 is the S_WAIT cycle in which tsent is first high
    task automatic send_word(input logic [7:0] d, input logic l, input int hold,
                             input int drop_at, input int es, input int el);
        bit dropped, done, all_ack;
        dropped = 0; done = 0;
        lat_we[0] = -1; lat_we[1] = -1; lat_we[2] = -1; lat_ack0 = -1;
        t_data = d; t_last = l; tsent = 1'b1;
        fifo_busy = (hold > 0);
        enable = !(es == 0 && el > 0);
        for (int n = 0; n < 3000 && !done; n++) begin
            @(negedge clk);
            if (fifo_we0 && lat_we[0] < 0) lat_we[0] = n;
            if (fifo_we1 && lat_we[1] < 0) lat_we[1] = n;
            if (fifo_we2 && lat_we[2] < 0) lat_we[2] = n;
            if (trecieve0 && lat_ack0 < 0) lat_ack0 = n;
            all_ack = trecieve0 && trecieve1 && trecieve2;
            if (dropped && fin0 && fin1 && fin2) begin
                done = 1;
            end else begin
                @(posedge clk); #1;
                if (!dropped && (all_ack || n + 1 >= drop_at)) begin
                    tsent = 1'b0;
                    dropped = 1;
                end
                fifo_busy = (n + 1 < hold);
                enable = !((n + 1) >= es && (n + 1) < es + el);
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL send_timeout word=%02h got=no_completion exp=completion", d);
        end
        @(posedge clk); #1;
        fifo_busy = 1'b0; enable = 1'b1;
        $display("word %02h last=%0d we_lat=%0d/%0d/%0d ack_lat=%0d", d, l,
                 lat_we[0], lat_we[1], lat_we[2], lat_ack0);
    endtask

    initial begin
        reset = 1'b0; enable = 1'b1; tsent = 1'b0; t_last = 1'b0;
        fifo_busy = 1'b0; t_data = 8'h00;

        vec[0] = '{8'h31, 1'b1, 0,   BIG, 0, 0, 9,   10,  3,   8'h97, 4'b0000};
        vec[1] = '{8'h31, 1'b1, 29,  BIG, 0, 0, 29,  30,  29,  8'h97, 4'b0000};
        vec[2] = '{8'h31, 1'b1, 264, BIG, 0, 0, 264, 265, 264, 8'h97, 4'b0000};
        vec[3] = '{8'h31, 1'b1, 265, BIG, 0, 0, 265, 266, 265, 8'h97, 4'b0100};
        vec[4] = '{8'h31, 1'b1, 0,   1,   0, 0, 9,   10,  3,   8'h97, 4'b0010};
        vec[5] = '{8'h31, 1'b1, 0,   BIG, 3, 5, 14,  15,  8,   8'h97, 4'b0000};
        vec[6] = '{8'h80, 1'b1, 0,   BIG, 0, 0, 9,   10,  3,   8'h89, 4'b0000};
        vec[7] = '{8'h0A, 1'b1, 0,   BIG, 0, 0, 9,   10,  3,   8'h36, 4'b0000};

        // Reset state
        @(negedge clk);
        chk("rst_fifo_data", fifo_data0, 8'h00);
        chk("rst_crc", crc0, 8'h00);
        chk("rst_we", fifo_we0, 1'b0);
        chk("rst_trecieve", trecieve0, 1'b0);
        chk("rst_isfinish", fin0, 1'b0);
        chk("rst_error", error0, 4'h0);
        do_reset();
        @(negedge clk);
        chk("wait_isfinish", fin0, 1'b1);
        @(posedge clk); #1;

        // Single-word packets: latency, busy stalls, early drop, enable freeze
        foreach (vec[i]) begin
            do_reset();
            send_word(vec[i].d, vec[i].l, vec[i].hold, vec[i].drop_at, vec[i].es, vec[i].el);
            exp_q.delete();
            exp_q.push_back(vec[i].d);
            exp_q.push_back(vec[i].crcw);
            chk($sformatf("v%0d_lat0", i), lat_we[0], vec[i].lat0);
            chk($sformatf("v%0d_ack0", i), lat_ack0, vec[i].ack0);
            chk($sformatf("v%0d_lat1", i), lat_we[1], vec[i].lat1);
            chk_stream($sformatf("v%0d_q0", i), 0);
            chk_stream($sformatf("v%0d_q1", i), 1);
            chk_stream($sformatf("v%0d_q2", i), 2);
            chk($sformatf("v%0d_err0", i), error0, vec[i].err0);
            chk($sformatf("v%0d_crc0", i), crc0, 8'h00);
        end

        // "123456789" packet
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 9; i++) begin
            send_word(8'h31 + 8'(i), i == 8, 0, BIG, 0, 0);
            chk($sformatf("s9_lat0_%0d", i), lat_we[0], 9);
            chk($sformatf("s9_lat1_%0d", i), lat_we[1], 3);
            exp_q.push_back(8'h31 + 8'(i));
        end
        exp_q.push_back(8'hF4);
        chk_stream("s9_q0", 0);
        chk_stream("s9_q1", 1);
        chk("s9_q2_len", q2.size() - b[2], 12);
        chk("s9_err0", error0, 4'h0);
        chk("s9_err2", error2, 4'b0001);

        // MAX_LEN=4 instance, 6 words without t_last
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            send_word((i == 0 || i == 4) ? 8'h31 : 8'h00, 1'b0, 0, BIG, 0, 0);
            if (i == 4) chk("ml_crc_reseed", crc2, 8'h97);
        end
        exp_q.push_back(8'h31); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        exp_q.push_back(8'h00); exp_q.push_back(8'hBF); exp_q.push_back(8'h31);
        exp_q.push_back(8'h00);
        chk_stream("ml_q2", 2);
        chk("ml_crc2", crc2, 8'hEC);
        chk("ml_err2", error2, 4'b0001);
        chk("ml_err0", error0, 4'h0);

        // Reset mid S_CRC discards the partial word and CRC
        do_reset();
        t_data = 8'h31; t_last = 1'b1; tsent = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        reset = 1'b0; tsent = 1'b0;
        #1;
        chk("mid_rst_fifo_data", fifo_data0, 8'h00);
        chk("mid_rst_crc", crc0, 8'h00);
        chk("mid_rst_we", fifo_we0, 1'b0);
        chk("mid_rst_isfinish", fin0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_no_write", q0.size() - b[0], 0);
        send_word(8'h31, 1'b1, 0, BIG, 0, 0);
        exp_q.delete(); exp_q.push_back(8'h31); exp_q.push_back(8'h97);
        chk_stream("mid_rst_q0", 0);

        // Request already high while leaving reset
        @(posedge clk); #1;
        reset = 1'b0; t_data = 8'h31; t_last = 1'b1; tsent = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        mark();
        send_word(8'h31, 1'b1, 0, BIG, 0, 0);
        chk_stream("early_req_q0", 0);
        chk("early_req_err0", error0, 4'b1000);

        chk("we_while_busy", viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
